dadda_mul_arbiter: RTL
======================

Name: dadda_mul_arbiter

Overview:
Arbiter/sequencer that shares one combinational 16x16 Dadda multiplier between two requesters. It accepts one operand pair at a time over valid/ready, drives the external multiplier's operand ports, and waits a programmable number of settle cycles. It then captures the 32-bit product and returns it to the owning requester over a valid/ready response channel. Requesters are arbitrated round-robin. The block sits between client logic and the single dadda instance.

Parameters:
W, 16, operand width; product width is 2*W
MUL_WAIT, 2, cycles operands are held on mul_a/mul_b before the product is captured; legal range 1..15

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operand pair
req0_ready  output  1  block accepts requester 0's pair this cycle
req0_a  input  W  requester 0 multiplier
req0_b  input  W  requester 0 multiplicand
req1_valid  input  1  requester 1 has an operand pair
req1_ready  output  1  block accepts requester 1's pair this cycle
req1_a  input  W  requester 1 multiplier
req1_b  input  W  requester 1 multiplicand
mul_a  output  W  operand A to the external multiplier, registered
mul_b  output  W  operand B to the external multiplier, registered
mul_p  input  2*W  product from the external multiplier
rsp0_valid  output  1  product ready for requester 0
rsp0_ready  input  1  requester 0 takes the product
rsp1_valid  output  1  product ready for requester 1
rsp1_ready  input  1  requester 1 takes the product
rsp_p  output  2*W  captured product, shared by both response channels
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, mul_a=0, mul_b=0, rsp_p=0, rsp0_valid=rsp1_valid=0, wait counter=0, last_grant=1 (requester 0 wins the first tie), owner=0. req0_ready and req1_ready are forced 0 while rst=1.
- State IDLE:
  - Grant is combinational. Only one valid -> grant that requester. Both valid -> grant the requester != last_grant. Neither -> no grant.
  - reqN_ready=1 only for the granted requester; the other ready=0. No ready is ever asserted outside IDLE.
  - Transfer occurs on a clock edge with reqN_valid & reqN_ready. At that edge: mul_a<=reqN_a, mul_b<=reqN_b, owner<=N, last_grant<=N, counter<=MUL_WAIT-1, state->MUL.
  - A valid dropped before ready carries no commitment; ready must not depend on a requester staying valid.
- State MUL:
  - mul_a and mul_b are held stable.
  - Each cycle with counter!=0, counter decrements.
  - On the edge where counter==0: rsp_p<=mul_p, rsp<owner>_valid<=1, state->RESP.
  - mul_a and mul_b keep their values after leaving MUL; they change only on the next accept.
- State RESP:
  - rsp<owner>_valid stays high and rsp_p is held stable until rsp<owner>_ready=1.
  - On that edge: valid<=0, state->IDLE.
  - No new request is accepted in the same cycle (no bypass). The non-owner response valid stays 0 throughout.
- Latency: accept at edge E -> rsp valid visible after edge E+MUL_WAIT. Minimum issue interval is MUL_WAIT+2 cycles (accept, MUL_WAIT-1 wait edges, capture, handshake back to IDLE).
- Arithmetic: the block never modifies the product; rsp_p = mul_p sampled at capture. A 0 operand yields 0. 65535*65534 = 4294770690 fits in 32 bits.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- Response backpressure: rsp_ready held low indefinitely keeps the block in RESP; pending requests keep waiting with ready=0.
- Reset mid-operation (any state): immediate return to reset values. The in-flight product is discarded and no response is issued.

Test Plan:
- Single request: req0 a=7239 b=49998, rsp0_ready=1, MUL_WAIT=2 -> rsp0_valid 2 cycles after accept, rsp_p=361935522, rsp1_valid stays 0.
- Tie after reset: req0 (23230,44371) and req1 (65535,65534) both valid in the same cycle -> req0 granted first with rsp_p=1030738330, then req1 with rsp_p=4294770690. Both ready never high together.
- Continuous contention, 4 ops per requester -> grant order 0,1,0,1,0,1,0,1. Each response is routed to the correct channel with the correct product.
- Backpressure: rsp1_ready held 0 for 10 cycles -> rsp1_valid stays 1, rsp_p stable, busy=1, req0_ready=0 throughout. Raising rsp1_ready -> IDLE next edge, then req0 accepted.
- Zero and max operands: (0,65535) -> rsp_p=0; (65535,65535) -> rsp_p=4294836225.
- Reset asserted in MUL state -> all outputs 0 asynchronously, no rsp valid. After release, a new req1 (3,5) returns rsp_p=15 on rsp1.

Source files
------------

// File: rtl/dadda_mul_arbiter.sv
// Round-robin sequencer sharing one combinational W x W multiplier between two
// requesters: accept an operand pair, hold it for MUL_WAIT cycles, return the product.
module dadda_mul_arbiter #(
   parameter int W        = 16,
   parameter int MUL_WAIT = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   output logic [W-1:0]   mul_a,
   output logic [W-1:0]   mul_b,
   input  logic [2*W-1:0] mul_p,
   output logic           rsp0_valid,
   input  logic           rsp0_ready,
   output logic           rsp1_valid,
   input  logic           rsp1_ready,
   output logic [2*W-1:0] rsp_p,
   output logic           busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(MUL_WAIT - 1);

   state_t     state, state_nxt;
   logic [3:0] count;
   logic       last_grant;
   logic       owner;
   logic       grant0, grant1;
   logic       accept0, accept1;
   logic       owner_ready;

   assign req0_ready  = grant0 & ~rst;
   assign req1_ready  = grant1 & ~rst;
   assign accept0     = req0_valid & req0_ready;
   assign accept1     = req1_valid & req1_ready;
   assign owner_ready = owner ? rsp1_ready : rsp0_ready;
   assign busy        = (state != IDLE);

   // Grant is only offered in IDLE; a tie goes to the requester not served last.
   always_comb begin
      grant0    = 1'b0;
      grant1    = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req0_valid && (!req1_valid || last_grant))
               grant0 = 1'b1;
            else if (req1_valid)
               grant1 = 1'b1;
            if (accept0 || accept1)
               state_nxt = MUL;
         end
         MUL: begin
            if (count == 4'd0)
               state_nxt = RESP;
         end
         RESP: begin
            if (owner_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         mul_a      <= '0;
         mul_b      <= '0;
         rsp_p      <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         count      <= 4'd0;
         last_grant <= 1'b1;
         owner      <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (accept0) begin
                  mul_a      <= req0_a;
                  mul_b      <= req0_b;
                  owner      <= 1'b0;
                  last_grant <= 1'b0;
                  count      <= WAIT_LOAD;
               end else if (accept1) begin
                  mul_a      <= req1_a;
                  mul_b      <= req1_b;
                  owner      <= 1'b1;
                  last_grant <= 1'b1;
                  count      <= WAIT_LOAD;
               end
            end
            MUL: begin
               // Operands have settled through the multiplier once the count reaches zero.
               if (count != 4'd0) begin
                  count <= count - 4'd1;
               end else begin
                  rsp_p <= mul_p;
                  if (owner)
                     rsp1_valid <= 1'b1;
                  else
                     rsp0_valid <= 1'b1;
               end
            end
            RESP: begin
               if (owner_ready) begin
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
